// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage LEGv8 core.
// Drives the PC/IF-ID write enables, the ID/EX bubble, per-stage flushes and
// the global freeze. It resolves data-memory waits, taken branches and
// load-use hazards in that priority order, and keeps saturating counters.
//
// Handshake: dmem_ready is a single-cycle completion strobe. While mem_access
// is high and dmem_ready is low, the access is outstanding and the pipeline
// freezes. The freeze lasts at most TIMEOUT consecutive cycles. The cycle in
// which mem_access and dmem_ready are both high completes the access.
module hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pipe_en,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             dbg_state
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_MWAIT = 1'b1
  } state_t;

  localparam int                WC_W      = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0]   TIMEOUT_V = WC_W'(TIMEOUT);
  localparam logic [REG_W-1:0]  XZR       = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            r_state;
  logic [WC_W-1:0]   r_wait_cnt;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  state_t            w_state_nxt;
  logic [WC_W-1:0]   w_wait_nxt;
  logic              w_err_nxt;
  logic              w_stall_inc;
  logic              w_flush_inc;
  logic              w_mem_block;
  logic              w_load_use;

  // Outstanding access, and a load in EX feeding a source register in ID (XZR never hazards)
  always_comb begin
    w_mem_block = mem_access && !dmem_ready;
    w_load_use  = ex_memread && (ex_rd != XZR) &&
                  ((id_uses_rn && (id_rn == ex_rd)) ||
                   (id_uses_rm && (id_rm == ex_rd)));
  end

  // Case selection: memory freeze, else (timeout fall-through) branch, load-use, normal
  always_comb begin
    w_state_nxt = ST_RUN;
    w_wait_nxt  = '0;
    w_err_nxt   = r_mem_err;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_en     = 1'b0;
    if (reset) begin
      if (w_mem_block && (r_wait_cnt < TIMEOUT_V)) begin
        // Whole pipeline held; a taken branch in MEM waits out the freeze
        w_state_nxt = ST_MWAIT;
        w_wait_nxt  = r_wait_cnt + WC_W'(1);
        w_stall_inc = 1'b1;
      end else begin
        // Still blocked here means the wait budget is spent: release and flag
        if (w_mem_block) begin
          w_err_nxt = 1'b1;
        end
        if (mem_branch_taken) begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          pipe_en     = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          w_flush_inc = 1'b1;
        end else if (w_load_use) begin
          idex_bubble = 1'b1;
          pipe_en     = 1'b1;
          w_stall_inc = 1'b1;
        end else begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          pipe_en     = 1'b1;
        end
      end
    end
  end

  // State, wait counter, sticky error and saturating counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_mem_err  <= w_err_nxt;
      if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_inc && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign dbg_state = r_state;

endmodule
